// File: rtl/fifo_param_pkg.sv
// Shared constants, flag bundle and elaboration-time helpers for the parametrised FWFT FIFO.
// Optional error flags are enabled by defining FIFO_ERR_FLAGS_EN.
package fifo_param_pkg;

  localparam int unsigned FIFO_MIN_DEPTH = 4;
  localparam int unsigned FIFO_MAX_DEPTH = 256;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  // Depth must be a power of two in range; levels must be reachable by the counter.
  function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                   input int unsigned af_level, input int unsigned ae_level);
    return (width >= 1) &&
           (depth >= FIFO_MIN_DEPTH) && (depth <= FIFO_MAX_DEPTH) &&
           ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Handshake/data bundle between a FIFO user (master) and fifo_param (slave).
// Error-flag signals exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_param_if import fifo_param_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();

  logic [WIDTH-1:0]       data_in;
  logic                   write;
  logic                   read;
  logic [WIDTH-1:0]       data_out;
  logic                   empty;
  logic                   full;
  logic                   almost_empty;
  logic                   almost_full;
  logic [clog2(DEPTH):0]  count;
`ifdef FIFO_ERR_FLAGS_EN
  logic                   overflow;
  logic                   underflow;
  logic                   err_clr;

  modport master (
    output data_in, write, read, err_clr,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
  modport slave (
    input  data_in, write, read, err_clr,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
`else
  modport master (
    output data_in, write, read,
    input  data_out, empty, full, almost_empty, almost_full, count
  );
  modport slave (
    input  data_in, write, read,
    output data_out, empty, full, almost_empty, almost_full, count
  );
`endif

endinterface

// File: rtl/fifo_param_dpram.sv
// WIDTH x DEPTH simple dual-port RAM: synchronous write, asynchronous read (distributed RAM).
module fifo_dpram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous first-word-fall-through FIFO with fill count and registered flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fifo_param import fifo_param_pkg::*; #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic          clk,
  input logic          rst,
  fifo_param_if.slave  bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_L     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L     = CW'(AE_LEVEL);
  localparam fifo_flags_t   FLAGS_RST = '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("fifo_param: illegal parameters WIDTH=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           WIDTH, DEPTH, AF_LEVEL, AE_LEVEL);
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  fifo_flags_t   flags_q, flags_d;
  logic          wr_acc, rd_acc;

  // A write while full is still accepted when a read frees the head slot in the same cycle.
  assign wr_acc = bus.write & (~flags_q.full | bus.read);
  assign rd_acc = bus.read & ~flags_q.empty;

  always_comb begin
    cnt_nxt = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_comb begin
    flags_d              = FLAGS_RST;
    flags_d.empty        = (cnt_nxt == '0);
    flags_d.full         = (cnt_nxt == CNT_FULL);
    flags_d.almost_empty = (cnt_nxt <= AE_L);
    flags_d.almost_full  = (cnt_nxt >= AF_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      cnt     <= cnt_nxt;
      flags_q <= flags_d;
    end
  end

  fifo_dpram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  assign bus.count        = cnt;
  assign bus.empty        = flags_q.empty;
  assign bus.full         = flags_q.full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.almost_full  = flags_q.almost_full;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Setting wins over err_clr so an error in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write & flags_q.full & ~bus.read) overflow_q <= 1'b1;
      else if (bus.err_clr)                     overflow_q <= 1'b0;
      if (bus.read & flags_q.empty)             underflow_q <= 1'b1;
      else if (bus.err_clr)                     underflow_q <= 1'b0;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (WIDTH=8, DEPTH=16, AF=14, AE=2) against a queue scoreboard.
// Works with FIFO_ERR_FLAGS_EN defined or undefined.
module tb_fifo_param;
  import fifo_param_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 14;
  localparam int unsigned AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] q[$];
  int unsigned  n_chk = 0;
  int unsigned  n_err = 0;
  bit           ov_m  = 1'b0;
  bit           un_m  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned n;
    n = q.size();
    check({tag, ".count"},        32'(bus.count),        n);
    check({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
    check({tag, ".full"},         32'(bus.full),         32'(n == D));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AF));
    if (n != 0) check({tag, ".head"}, 32'(bus.data_out), 32'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"},  32'(bus.overflow),  32'(ov_m));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(un_m));
`endif
  endtask

  // One clock: drive inputs, update scoreboard (popped word checked before the edge), check after.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c,
                      input bit rs, input string tag);
    int unsigned n;
    bit wa, ra;
    n = q.size();
    rst          = rs;
    bus.write    = w;
    bus.data_in  = d;
    bus.read     = r;
`ifdef FIFO_ERR_FLAGS_EN
    bus.err_clr  = c;
`endif
    if (rs) begin
      q.delete();
      ov_m = 1'b0;
      un_m = 1'b0;
    end else begin
      wa = w && (n != D || r);
      ra = r && (n != 0);
      if (ra) begin
        check({tag, ".pop"}, 32'(bus.data_out), 32'(q[0]));
        void'(q.pop_front());
      end
      if (wa) q.push_back(d);
      if (w && n == D && !r) ov_m = 1'b1;
      else if (c)            ov_m = 1'b0;
      if (r && n == 0)       un_m = 1'b1;
      else if (c)            un_m = 1'b0;
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.write = 1'b0;
    bus.read  = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    bus.err_clr = 1'b0;
`endif
    check_state(tag);
  endtask

  initial begin
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = '0;
`ifdef FIFO_ERR_FLAGS_EN
    bus.err_clr = 1'b0;
`endif

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "reset");
    check("reset.count_zero", 32'(bus.count), 32'd0);
    check("reset.empty_one",  32'(bus.empty), 32'd1);

    // Fall-through of a single word
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "fwft");
    check("fwft.data", 32'(bus.data_out), 32'h0000_00A5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "fwft_read");

    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
    check("fill.full", 32'(bus.full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "over");
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
    check("drain.empty", 32'(bus.empty), 32'd1);

    // Simultaneous write+read while full, pointers wrap
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, "fill2");
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0, "wr_rd_full");
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain2");

    // Write+read on empty, then read on empty, then error-flag clearing
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, "wr_rd_empty");
    check("wr_rd_empty.data", 32'(bus.data_out), 32'h0000_0033);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop33");
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "under");
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "under_setclr");
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "err_clr");

    // Reset mid-burst with write asserted
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, "fill10");
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, "rst_mid");
    check("rst_mid.count", 32'(bus.count), 32'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "post_rst");

    // Random traffic, biased towards filling then towards draining
    for (int i = 0; i < 10000; i++) begin
      bit w, r, c;
      if (i < 5000) begin
        w = ($urandom_range(0, 99) < 70);
        r = ($urandom_range(0, 99) < 40);
      end else begin
        w = ($urandom_range(0, 99) < 40);
        r = ($urandom_range(0, 99) < 70);
      end
      c = ($urandom_range(0, 99) < 5);
      step(w, 8'($urandom_range(0, 255)), r, c, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
